// File: rtl/wb_pkg.sv
// Shared types and constants for the write-back stage: result selector,
// load funct3 encodings and FSM states.
package wb_pkg;

  typedef enum logic [1:0] {
    WB_ALU = 2'b00,
    WB_MEM = 2'b01,
    WB_PC4 = 2'b10,
    WB_IMM = 2'b11
  } wb_sel_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    WAIT_MEM = 2'b01,
    DRAIN    = 2'b10
  } wb_state_e;

endpackage

// File: rtl/wb_stage_load_align.sv
// Combinational load aligner: picks the byte/half/word addressed by off out of
// the memory response word and sign- or zero-extends it to XLEN.
module load_align #(
  parameter int XLEN  = 32,
  parameter int OFF_W = $clog2(XLEN/8)
) (
  input  logic [XLEN-1:0]  rdata,
  input  logic [2:0]       funct3,
  input  logic [OFF_W-1:0] off,
  output logic [XLEN-1:0]  data
);
  import wb_pkg::*;

  logic [XLEN-1:0] byte_sh;
  logic [XLEN-1:0] half_sh;
  logic [XLEN-1:0] word_sh;

  // Halfword offset drops off[0]; misaligned halves are trapped upstream.
  always_comb begin
    byte_sh = rdata >> {off, 3'b000};
    half_sh = rdata >> {off[OFF_W-1:1], 4'b0000};
    word_sh = rdata;
    if (XLEN == 64) begin
      word_sh = rdata >> {off[OFF_W-1], 5'b00000};
    end
  end

  always_comb begin
    data = '0;
    case (funct3)
      F3_LB: begin
        data      = {XLEN{byte_sh[7]}};
        data[7:0] = byte_sh[7:0];
      end
      F3_LBU: data[7:0] = byte_sh[7:0];
      F3_LH: begin
        data       = {XLEN{half_sh[15]}};
        data[15:0] = half_sh[15:0];
      end
      F3_LHU: data[15:0] = half_sh[15:0];
      F3_LW: begin
        data       = {XLEN{word_sh[31]}};
        data[31:0] = word_sh[31:0];
      end
      F3_LWU: begin
        if (XLEN == 64) begin
          data[31:0] = word_sh[31:0];
        end
      end
      F3_LD: begin
        if (XLEN == 64) begin
          data = rdata;
        end
      end
      default: data = '0;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// Registered write-back stage: selects the result, waits for late loads and
// drives the register-file write port. WB_PERF_EN adds retire/stall counters.
module wb_stage #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5,
  parameter int OFF_W  = $clog2(XLEN/8)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [XLEN-1:0]   pc_i,
  input  logic [XLEN-1:0]   alu_i,
  input  logic [XLEN-1:0]   imm_i,
  input  logic [1:0]        wb_sel_i,
  input  logic [REG_AW-1:0] rd_addr_i,
  input  logic              rd_we_i,
  input  logic [2:0]        ld_funct3_i,
  input  logic [OFF_W-1:0]  ld_off_i,
  input  logic              mem_rvalid_i,
  input  logic [XLEN-1:0]   mem_rdata_i,
  input  logic              flush_i,
  output logic              rf_we_o,
  output logic [REG_AW-1:0] rf_waddr_o,
  output logic [XLEN-1:0]   rf_wdata_o,
  output logic              busy_o
`ifdef WB_PERF_EN
  ,
  output logic [31:0]       retire_cnt_o,
  output logic [31:0]       ld_stall_cnt_o
`endif
);
  import wb_pkg::*;

  wb_state_e         state_q, state_d;
  logic [REG_AW-1:0] rd_q, rd_d;
  logic              rd_we_q, rd_we_d;
  logic [2:0]        f3_q, f3_d;
  logic [OFF_W-1:0]  off_q, off_d;
  logic              rf_we_q, rf_we_d;
  logic [REG_AW-1:0] rf_waddr_q, rf_waddr_d;
  logic [XLEN-1:0]   rf_wdata_q, rf_wdata_d;

  wb_sel_e           sel;
  logic [2:0]        la_f3;
  logic [OFF_W-1:0]  la_off;
  logic [XLEN-1:0]   ld_data;
  logic [XLEN-1:0]   sel_data;
  logic              done;
  logic [REG_AW-1:0] done_rd;
  logic              done_we;
  logic [XLEN-1:0]   done_data;

  // A waiting load aligns with its captured type/offset, otherwise the live ones.
  always_comb begin
    la_f3  = (state_q == WAIT_MEM) ? f3_q  : ld_funct3_i;
    la_off = (state_q == WAIT_MEM) ? off_q : ld_off_i;
  end

  load_align #(
    .XLEN  (XLEN),
    .OFF_W (OFF_W)
  ) u_load_align (
    .rdata  (mem_rdata_i),
    .funct3 (la_f3),
    .off    (la_off),
    .data   (ld_data)
  );

  always_comb begin
    sel = wb_sel_e'(wb_sel_i);
    case (sel)
      WB_ALU:  sel_data = alu_i;
      WB_PC4:  sel_data = pc_i + XLEN'(4);
      WB_IMM:  sel_data = imm_i;
      default: sel_data = ld_data;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    rd_d      = rd_q;
    rd_we_d   = rd_we_q;
    f3_d      = f3_q;
    off_d     = off_q;
    done      = 1'b0;
    done_rd   = rd_addr_i;
    done_we   = rd_we_i;
    done_data = sel_data;
    case (state_q)
      IDLE: begin
        if (in_valid_i && !flush_i) begin
          if (sel != WB_MEM || mem_rvalid_i) begin
            done = 1'b1;
          end else begin
            state_d = WAIT_MEM;
            rd_d    = rd_addr_i;
            rd_we_d = rd_we_i;
            f3_d    = ld_funct3_i;
            off_d   = ld_off_i;
          end
        end
      end
      WAIT_MEM: begin
        done_rd   = rd_q;
        done_we   = rd_we_q;
        done_data = ld_data;
        if (mem_rvalid_i) begin
          state_d = IDLE;
          done    = !flush_i;
        end else if (flush_i) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (mem_rvalid_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // x0 is hardwired, so a completion targeting it never pulses the write port.
    rf_we_d    = done && done_we && (done_rd != '0);
    rf_waddr_d = rf_we_d ? done_rd   : rf_waddr_q;
    rf_wdata_d = rf_we_d ? done_data : rf_wdata_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      rd_q       <= '0;
      rd_we_q    <= 1'b0;
      f3_q       <= '0;
      off_q      <= '0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
    end else begin
      state_q    <= state_d;
      rd_q       <= rd_d;
      rd_we_q    <= rd_we_d;
      f3_q       <= f3_d;
      off_q      <= off_d;
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
    end
  end

  assign in_ready_o = (state_q == IDLE);
  assign busy_o     = (state_q != IDLE);
  assign rf_we_o    = rf_we_q;
  assign rf_waddr_o = rf_waddr_q;
  assign rf_wdata_o = rf_wdata_q;

`ifdef WB_PERF_EN
  logic        retire_q, retire_d;
  logic [31:0] retire_cnt_q, retire_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;

  // Retirement is counted in the cycle the write port shows it; both saturate.
  always_comb begin
    retire_d     = done;
    retire_cnt_d = retire_cnt_q;
    stall_cnt_d  = stall_cnt_q;
    if (retire_q && retire_cnt_q != 32'hFFFF_FFFF) begin
      retire_cnt_d = retire_cnt_q + 32'd1;
    end
    if (state_q == WAIT_MEM && stall_cnt_q != 32'hFFFF_FFFF) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      retire_q     <= 1'b0;
      retire_cnt_q <= '0;
      stall_cnt_q  <= '0;
    end else begin
      retire_q     <= retire_d;
      retire_cnt_q <= retire_cnt_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

  assign retire_cnt_o   = retire_cnt_q;
  assign ld_stall_cnt_o = stall_cnt_q;
`endif

endmodule
